// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared widths, state encoding and count type
// for the counter_ctrl sequencer and its rate divider.
package counter_ctrl_pkg;

  localparam int CNT_W = 8;
  localparam int DIV_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } ctrl_state_t;

  typedef logic [CNT_W-1:0] count_t;

endpackage

// File: rtl/counter_ctrl_rate_tick.sv
// rate_tick: reloading down-counter; Tick is high while it sits at
// zero, giving one tick every LoadValue+1 unheld cycles.
module rate_tick #(
  parameter int DIV_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Hold,
  input  logic [DIV_W-1:0] LoadValue,
  output logic             Tick
);

  logic [DIV_W-1:0] cnt;

  assign Tick = (cnt == '0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= '0;
    end else if (Load) begin
      cnt <= LoadValue;
    end else if (!Hold) begin
      cnt <= Tick ? LoadValue : cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: run/pause/done sequencer for the 8-bit enable counter.
// Optional COUNTER_CTRL_AUTO_RELOAD_EN restarts each run on reaching target.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int CNT_W = counter_ctrl_pkg::CNT_W,
  parameter int DIV_W = counter_ctrl_pkg::DIV_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Pause,
  input  logic             Abort,
  input  logic [CNT_W-1:0] Target,
  input  logic [DIV_W-1:0] Divisor,
  input  logic [CNT_W-1:0] CounterValue,
  output logic             CountEnable,
  output logic             CountClear,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       StateOut
);

  ctrl_state_t      state;
  logic [CNT_W-1:0] target_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] reload;
  logic             tick;
  logic             hit;
  logic             fin;

  assign div_eff = (Divisor == '0) ? DIV_W'(1) : Divisor;
  assign reload  = div_q - DIV_W'(1);

  // The clear cycle neither counts nor compares: the counter still
  // shows the previous run's value there.
  assign CountEnable = (state == S_RUN) && !CountClear && tick &&
                       (CounterValue != target_q);

  assign hit = (state == S_RUN) && !CountClear &&
               (CounterValue == target_q);

`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
  // Clear on the final enable so the wrap costs only one cycle.
  assign fin = hit ||
               (CountEnable &&
                (CounterValue == target_q - CNT_W'(1)));
`else
  assign fin = hit;
`endif

  assign StateOut = state;

  rate_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .Clock    (Clock),
    .Reset    (Reset),
    .Load     (CountClear),
    .Hold     (state != S_RUN),
    .LoadValue(reload),
    .Tick     (tick)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= S_IDLE;
      target_q   <= '0;
      div_q      <= DIV_W'(1);
      CountClear <= 1'b0;
      Done       <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      CountClear <= 1'b0;
      Done       <= 1'b0;
      if (Abort) begin
        state      <= S_IDLE;
        CountClear <= 1'b1;
        Busy       <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE, S_DONE: begin
            if (Start) begin
              target_q   <= Target;
              div_q      <= div_eff;
              CountClear <= 1'b1;
              if (Target == '0) begin
                state <= S_DONE;
                Done  <= 1'b1;
                Busy  <= 1'b0;
              end else begin
                state <= S_RUN;
                Busy  <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (fin) begin
              Done <= 1'b1;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
              CountClear <= 1'b1;
`else
              state <= S_DONE;
              Busy  <= 1'b0;
`endif
            end else if (Pause) begin
              state <= S_PAUSE;
            end
          end
          S_PAUSE: begin
            if (Start) begin
              state <= S_RUN;
            end
          end
          default: begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Sequencer for the team's 8-bit T-flip-flop ripple-enable counter.
- Generates the counter's Enable at a programmable rate and clears the counter at the start of a run.
- Watches the counter's CounterValue and stops it exactly at a programmed target.
- Sits between the top-level control (keys or CPU registers) and the counter instance. Replaces hand-driven Enable.

Parameters:
CNT_W, 8, counter width; must match the driven counter.
DIV_W, 16, width of the rate divisor.

Ports:
Clock  input  1  system clock; all state changes on posedge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  level-sampled each cycle; begins a run, or resumes from PAUSE.
Pause  input  1  freezes the run while in RUN.
Abort  input  1  cancels from any state.
Target  input  CNT_W  terminal count; latched on Start.
Divisor  input  DIV_W  cycles per count step; latched on Start; 0 is treated as 1.
CounterValue  input  CNT_W  present value of the driven counter.
CountEnable  output  1  drives the counter's Enable.
CountClear  output  1  drives the counter's Reset; one-cycle pulse.
Busy  output  1  high in RUN and PAUSE.
Done  output  1  one-cycle completion pulse.
StateOut  output  2  current state encoding, for debug/LEDs.

Behaviour:
- States and encodings: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- Reset values: state IDLE; all outputs 0; TargetQ 0; DivQ 1; divider 0.
- Input priority within a cycle: Reset > Abort > Start > Pause.
- Abort (any state): next state IDLE; CountClear=1 for that one cycle.
- IDLE or DONE, on Start:
  - latch TargetQ=Target and DivQ=max(Divisor,1);
  - CountClear=1 for one cycle;
  - load divider with DivQ-1;
  - next state RUN; if Target==0, next state DONE instead, and Done pulses on entry.
- RUN, divider and enable:
  - divider decrements each cycle; when it is 0, tick=1 and it reloads DivQ-1.
  - CountEnable = (state==RUN) && tick && (CounterValue!=TargetQ), combinational, so the counter never overshoots.
  - DivQ=1 means CountEnable is high every cycle.
- RUN, completion:
  - when CounterValue==TargetQ, next state DONE.
  - Done=1 for exactly the first cycle in DONE.
- RUN, other inputs: Pause moves to PAUSE. Start is ignored.
- PAUSE:
  - divider frozen; CountEnable=0; counter holds its value.
  - Start moves back to RUN with no clear and no divider reload.
  - Pause held continuously keeps the state in PAUSE.
- DONE: CountEnable=0; Busy=0; counter holds TargetQ until Start or Abort.
- Timing: from the Start cycle, Done asserts TargetQ*DivQ+2 cycles later (1 clear cycle, TargetQ*DivQ counting cycles, 1 cycle detection register).
- Target and Divisor changes mid-run have no effect until the next Start.
- Counter wrap cannot occur: TargetQ ≤ 2^CNT_W−1 and enable is gated at TargetQ.
- Reset asserted mid-run: IDLE next cycle; CountClear is not asserted (the counter shares Reset).

Optional Feature:
- Macro: COUNTER_CTRL_AUTO_RELOAD_EN.
- Defined: on reaching TargetQ in RUN, Done pulses and CountClear pulses in the same cycle, the divider reloads, and the state stays RUN. This gives a periodic run of period (TargetQ*DivQ+1) cycles, and DONE is unreachable except via Target==0. Abort and Pause behave unchanged.
- Undefined: behaviour as above; a run is one-shot.

Decomposition:
- Package counter_ctrl_pkg holds:
  - CNT_W and DIV_W default constants;
  - typedef enum logic [1:0] ctrl_state_t {S_IDLE, S_RUN, S_PAUSE, S_DONE};
  - typedef logic [CNT_W-1:0] count_t.
- Sub-module rate_tick (DIV_W parameter) holds the down-counter divider.
  - Ports: Clock, Reset, Load, Hold, LoadValue → Tick.
- counter_ctrl contains the FSM, the latches and the compare. The bench instantiates counter_ctrl with the existing 8-bit counter.

Test Plan:
- Divisor=1, Target=5, Start pulse → CountClear at cycle 0; CountEnable high cycles 1–5; CounterValue reaches 5; Done pulses at cycle 7; counter holds 5.
- Divisor=4, Target=3 → CountEnable high only on cycles 4, 8, 12; Done at cycle 14; no overshoot to 4.
- Divisor=3, Target=10; Pause at CounterValue=4 for 20 cycles, then Start → value stays 4 during pause; phase continues without clear; Done at 30+2+20 cycles after the original Start.
- Abort at CounterValue=7 with Target=200 → IDLE next cycle; CountClear pulse; CounterValue 0; no Done.
- Target=0, Start → DONE next cycle, Done pulse, CountEnable never high. Also Divisor=0 behaves as Divisor=1.
- With COUNTER_CTRL_AUTO_RELOAD_EN, Divisor=1, Target=2 → Done pulses every 3 cycles; CounterValue sequence 0,1,2,0,1,2; Busy stays 1.
